// File: rtl/seq_alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered, enable-gated ALU among N_REQ requesters.
// Optional op_count statistics output enabled by defining SEQ_ALU_ARB_STATS_EN.
module seq_alu_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [2*N_REQ-1:0]       req_opcode,
    input  logic [DATA_W*N_REQ-1:0]  req_a,
    input  logic [DATA_W*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W:0]          rsp_data,
    output logic                     alu_en,
    output logic [1:0]               alu_opcode,
    output logic [DATA_W-1:0]        alu_a,
    output logic [DATA_W-1:0]        alu_b,
    input  logic [DATA_W:0]          alu_c
`ifdef SEQ_ALU_ARB_STATS_EN
    ,
    output logic [15:0]              op_count
`endif
);

    localparam int unsigned NU    = N_REQ;
    localparam int          IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic              pick_found;
    logic [1:0]        sel_opcode;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Search starts one past the previous winner and wraps, so every requester is reached.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NU; k++) begin
            cand = IDX_W'((32'(last_grant) + k) % NU);
            if (!pick_found && req_valid[cand]) begin
                pick_idx   = cand;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_opcode = '0;
        sel_a      = '0;
        sel_b      = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                sel_opcode = req_opcode[2*i +: 2];
                sel_a      = req_a[DATA_W*i +: DATA_W];
                sel_b      = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // Ready is gated by reset so no handshake can be seen while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && rst && pick_found)
            req_ready[pick_idx] = 1'b1;
    end

    always_comb begin
        rsp_valid = '0;
        if (state == S_RESP)
            rsp_valid[grant_idx] = 1'b1;
    end

    assign alu_en = (state == S_ISSUE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            last_grant <= IDX_W'(N_REQ - 1);
            grant_idx  <= '0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        alu_opcode <= sel_opcode;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE:   state <= S_CAPTURE;
                S_CAPTURE: begin
                    rsp_data <= alu_c;
                    state    <= S_RESP;
                end
                default:   state <= S_IDLE;
            endcase
        end
    end

`ifdef SEQ_ALU_ARB_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            op_count_q <= '0;
        else if (state == S_RESP && op_count_q != 16'hFFFF)
            op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: doc/seq_alu_arbiter.md
# seq_alu_arbiter

Round-robin arbiter and sequencer that shares one sequential ALU (2-bit opcode, registered result, `en`-gated) among `N_REQ` requesters. Each requester hands over one operation with a valid/ready handshake. The block latches the operation, pulses the ALU enable for one cycle, captures the registered result, and returns it to the originating requester as a one-cycle response pulse. It sits directly in front of the ALU and is the ALU's only driver.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 4, operand width; result width is `DATA_W+1`
- `clk`  in  1  single clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  N_REQ  per-requester operation valid
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high
- `req_opcode`  in  2*N_REQ  flattened opcodes; requester i uses bits [2i+1:2i]; ADD=0, SUB=1, AND=2, OR=3
- `req_a`, `req_b`  in  DATA_W*N_REQ  flattened operands, slice i belongs to requester i
- `rsp_valid`  out  N_REQ  one-cycle result pulse to the owning requester
- `rsp_data`  out  DATA_W+1  result, shared by all requesters; meaningful only while a `rsp_valid` bit is high
- `alu_en`  out  1  ALU enable
- `alu_opcode`  out  2  ALU opcode
- `alu_a`, `alu_b`  out  DATA_W  ALU operands
- `alu_c`  in  DATA_W+1  registered ALU result

## Operation
- FSM states: IDLE → ISSUE → CAPTURE → RESP → IDLE. Each non-IDLE state lasts exactly one cycle.
- **IDLE**
  - If any `req_valid` bit is high, pick `g` round-robin, searching from `last_grant+1` upward with wrap at `N_REQ-1` → 0.
  - Drive `req_ready[g]=1` combinationally; all other `req_ready` bits are 0.
  - At the clock edge, latch `req_opcode`, `req_a` and `req_b` of requester `g` into `alu_opcode`, `alu_a` and `alu_b`, store `g`, set `last_grant=g`, and go to ISSUE.
  - If no `req_valid` bit is high, stay in IDLE with `req_ready=0`.
- **ISSUE**: `alu_en=1` for exactly this cycle. The ALU updates `alu_c` at the closing edge.
- **CAPTURE**: `alu_en=0`. Register `alu_c` into `rsp_data` at the closing edge.
- **RESP**: `rsp_valid[g]=1` for one cycle. There is no response backpressure: the requester must take the result in this cycle.
- Outside ISSUE, `alu_en=0`, so the ALU result holds stable.
- `alu_opcode`, `alu_a` and `alu_b` hold their latched values until the next grant.
- `req_ready` is 0 in every non-IDLE state, so a new request can only be accepted in IDLE.
- The arbiter does not alter the result.
  - ADD carry appears in bit `DATA_W`.
  - SUB wraps modulo 2^(DATA_W+1), e.g. 3−5 = 5'd30.
  - AND/OR results have bit `DATA_W` = 0.
- Requester obligations: hold `req_valid` and the payload stable until `req_ready` is seen. Deasserting `req_valid` before the grant is legal and withdraws the request.

## Timing
- Reset values:
  - state = IDLE, `last_grant = N_REQ-1` (requester 0 wins first)
  - `req_ready`, `rsp_valid`, `alu_en`, `alu_opcode`, `alu_a`, `alu_b`, `rsp_data` all 0
- Latency: handshake at edge T → `alu_en` high in cycle T+1 → `alu_c` valid in cycle T+2 → `rsp_valid` high in cycle T+3.
- Throughput: one operation per 4 cycles. A requester may re-request in the same cycle as its `rsp_valid`.
- Simultaneous requests:
  - Exactly one is granted per IDLE visit.
  - With all `N_REQ` requesters continuously valid, grants rotate 0,1,2,…,N_REQ-1,0.
  - Maximum wait before a grant is (N_REQ-1) operations.
- A requester asserting `req_valid` while another operation is in flight waits; the request is not lost.
- Reset asserted mid-operation:
  - Immediately forces IDLE and all outputs to their reset values.
  - The in-flight operation is dropped and no `rsp_valid` is issued for it.
  - `last_grant` returns to `N_REQ-1`.

## Configuration
- Macro `SEQ_ALU_ARB_STATS_EN`.
  - Defined: adds output `op_count` (16 bits), reset to 0. It increments by 1 in every RESP cycle and saturates at 16'hFFFF.
  - Undefined: the `op_count` port and its counter are absent. All other behaviour is identical.

## Test plan
- **Reset:** hold `rst=0` for 3 cycles → all outputs 0. Release reset → first grant with all requests valid goes to requester 0.
- **Single ADD:** requester 2 sends ADD with A=9, B=8 → `req_ready[2]` at T, `alu_en` at T+1 only, `rsp_valid[2]` at T+3 with `rsp_data`=5'd17.
- **Opcodes:** SUB 3−5 → 5'd30. AND 4'hC & 4'hA → 5'd8. OR 4'hC | 4'h3 → 5'd15. `alu_c` holds its value on every non-ISSUE cycle.
- **Fairness:** all 4 requesters valid continuously for 16 operations → grant order 0,1,2,3 repeated 4 times, each response routed to the correct `rsp_valid` bit.
- **Mid-operation reset:** assert `rst=0` in the CAPTURE cycle → no `rsp_valid` pulse. After release, the pending requester is granted with a fresh latency of 3 cycles.
- **Stats (`SEQ_ALU_ARB_STATS_EN`):** 5 completed operations → `op_count`=5. Preload to 16'hFFFE and complete 3 operations → `op_count`=16'hFFFF.
